vigna_coproc_issue: RTL and testbench
=====================================

VIGNA_COPROC_ISSUE -- requirements
Module: vigna_coproc_issue

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the number of cycles to wait for coprocessor ready before the request is aborted (valid 2..255).
REQ-002 SHALL have ports clk input 1 (clock) and resetn input 1 (reset; synchronous, active-low).
REQ-003 SHALL have request ports:
- req_valid input 1
- req_ready output 1
- req_sel input 1 (0=M unit, 1=F unit)
- req_func input 3
- req_func2 input 5
- req_rd input 5
- req_op1 input 32
- req_op2 input 32
REQ-004 SHALL have shared coprocessor operand ports:
- cp_func output 3
- cp_func2 output 5
- cp_id output 3 (issue tag)
- cp_op1 output 32
- cp_op2 output 32
REQ-005 SHALL have per-unit handshake ports:
- m_valid output 1, m_ready input 1, m_result input 32
- f_valid output 1, f_ready input 1, f_result input 32
REQ-006 SHALL have writeback ports:
- wb_valid output 1
- wb_ready input 1
- wb_rd output 5
- wb_data output 32
- wb_err output 1
- busy output 1

Function
REQ-007 SHALL implement states IDLE, ISSUE and WB.
REQ-008 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1.
REQ-009 On accept, SHALL register func, func2, op1, op2, rd and sel, increment cp_id (wrapping 7->0), move to ISSUE, and assert the selected unit's valid from the next cycle.
REQ-010 SHALL hold cp_func, cp_func2, cp_id, cp_op1 and cp_op2 stable from accept until the state leaves ISSUE, because units read operands during multi-cycle computation.
REQ-011 In ISSUE, SHALL keep exactly one valid asserted (m_valid if sel=0, f_valid if sel=1); the other valid SHALL be 0.
REQ-012 On the edge where the selected unit's ready is sampled 1, SHALL deassert valid on that same edge, capture the selected result into wb_data, and move to WB.
REQ-013 If rd=0 when ready is sampled, SHALL discard the result and go directly to IDLE, with no wb_valid.
REQ-014 In WB, SHALL hold wb_valid=1 with wb_rd and wb_data stable until wb_ready=1 is sampled, then go to IDLE.
REQ-015 SHALL ignore m_ready and f_ready in IDLE and WB, and SHALL ignore the non-selected unit's ready in ISSUE.
REQ-016 SHALL keep the minimum latency from accept to wb_valid at 2 cycles plus coprocessor latency.
REQ-017 SHALL drive busy=1 whenever the state is not IDLE.

Reset
REQ-018 With resetn=0 at a clock edge, SHALL force state IDLE and drive all outputs to 0, including cp_id; any in-flight request is abandoned without writeback.

Configuration
REQ-019 With VIGNA_COPROC_TIMEOUT_EN defined:
- a counter clears on accept and counts cycles spent in ISSUE.
- When it reaches TIMEOUT_CYCLES, the block SHALL deassert valid and enter WB with wb_err=1 and wb_data=0.
- A ready arriving later SHALL be ignored per REQ-015.
- The rd=0 rule still applies: no writeback is issued.
REQ-020 Without VIGNA_COPROC_TIMEOUT_EN, SHALL omit the counter, tie wb_err to 0, and wait in ISSUE indefinitely.

Structure
REQ-021 SHALL take from shared package vigna_coproc_pkg: the state encoding, the SEL_M/SEL_F constants, the M funct3 codes (MUL..REMU), and the F func2 codes (FADD, FSUB, FMUL, FDIV, FMV, FCVT).
REQ-022 SHALL implement the timeout counter as sub-module vigna_coproc_watchdog, instantiated only under VIGNA_COPROC_TIMEOUT_EN.

Verification
REQ-023 SHALL verify MUL: sel=0, func=000, op1=7, op2=6, rd=5 -> m_valid held, operands stable; wb_valid with wb_rd=5, wb_data=42.
REQ-024 SHALL verify DIVU by zero: sel=0, func=101, op1=100, op2=0, rd=3 -> wb_data=0xFFFFFFFF.
REQ-025 SHALL verify FADD: sel=1, func2=00000, op1=0x3F800000, op2=0x40000000, rd=1 -> f_valid only, wb_data=0x40400000.
REQ-026 SHALL verify writeback backpressure and rd=0:
- MUL rd=0 -> no wb_valid, busy returns to 0.
- wb_ready held 0 for 10 cycles -> wb_data stable and req_ready=0 throughout.
REQ-027 SHALL verify timeout: with the macro defined, ready never asserted -> wb_err=1 and wb_data=0 exactly TIMEOUT_CYCLES=64 cycles after entering ISSUE; a late ready pulse is ignored.
REQ-028 SHALL verify reset mid-ISSUE: resetn=0 for 1 cycle -> all outputs 0 next cycle, cp_id=0, and a new request is accepted normally.

Source files
------------

// File: rtl/vigna_coproc_pkg.sv
// vigna_coproc_pkg: shared definitions for the Vigna coprocessor issue path.
// Holds the issue FSM state encoding, the M/F unit select values and the
// operation codes the M (funct3) and F (func2) units understand.
package vigna_coproc_pkg;

    // Issue FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WB    = 2'd2;

    // Unit select carried on req_sel
    localparam logic SEL_M = 1'b0;
    localparam logic SEL_F = 1'b1;

    // M unit funct3 codes (RV32M ordering)
    localparam logic [2:0] M_MUL    = 3'b000;
    localparam logic [2:0] M_MULH   = 3'b001;
    localparam logic [2:0] M_MULHSU = 3'b010;
    localparam logic [2:0] M_MULHU  = 3'b011;
    localparam logic [2:0] M_DIV    = 3'b100;
    localparam logic [2:0] M_DIVU   = 3'b101;
    localparam logic [2:0] M_REM    = 3'b110;
    localparam logic [2:0] M_REMU   = 3'b111;

    // F unit func2 codes
    localparam logic [4:0] F_FADD = 5'b00000;
    localparam logic [4:0] F_FSUB = 5'b00001;
    localparam logic [4:0] F_FMUL = 5'b00010;
    localparam logic [4:0] F_FDIV = 5'b00011;
    localparam logic [4:0] F_FMV  = 5'b11100;
    localparam logic [4:0] F_FCVT = 5'b11000;

    // Issue tags are 3 bits and wrap 7 -> 0
    function automatic logic [2:0] next_tag(input logic [2:0] tag);
        return tag + 3'd1;
    endfunction

endpackage

// File: rtl/vigna_coproc_watchdog.sv
// vigna_coproc_watchdog: counts cycles a request spends waiting in ISSUE and
// flags expiry once TIMEOUT_CYCLES cycles have elapsed since accept.
// Only instantiated when VIGNA_COPROC_TIMEOUT_EN is defined.
module vigna_coproc_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;

    // The count seen at an edge equals the ISSUE edges already spent, so
    // expiry fires on the TIMEOUT_CYCLES-th edge after accept.
    assign o_expired = i_run && (r_count == LAST_COUNT);

    // Cycle counter: cleared on accept, advances while the request waits
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_run && !o_expired) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/vigna_coproc_issue.sv
// vigna_coproc_issue: accepts one coprocessor request at a time, presents its
// operands to the M or F unit, waits for that unit's ready, then hands the
// result to writeback (skipped for rd=0).
// Optional feature: define VIGNA_COPROC_TIMEOUT_EN to abort a request after
// TIMEOUT_CYCLES cycles in ISSUE, reporting wb_err=1 with wb_data=0.
module vigna_coproc_issue
    import vigna_coproc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_sel,
    input  logic [2:0]  req_func,
    input  logic [4:0]  req_func2,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,

    output logic [2:0]  cp_func,
    output logic [4:0]  cp_func2,
    output logic [2:0]  cp_id,
    output logic [31:0] cp_op1,
    output logic [31:0] cp_op2,

    output logic        m_valid,
    input  logic        m_ready,
    input  logic [31:0] m_result,
    output logic        f_valid,
    input  logic        f_ready,
    input  logic [31:0] f_result,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        busy
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("vigna_coproc_issue: TIMEOUT_CYCLES must be within 2..255");
    end

    logic [1:0]  r_state;
    logic        r_req_ready;
    logic        r_sel;
    logic [2:0]  r_func;
    logic [4:0]  r_func2;
    logic [4:0]  r_rd;
    logic [31:0] r_op1;
    logic [31:0] r_op2;
    logic [2:0]  r_id;
    logic        r_m_valid;
    logic        r_f_valid;
    logic        r_wb_valid;
    logic [31:0] r_wb_data;
    logic        r_wb_err;

    logic        w_accept;
    logic        w_in_issue;
    logic        w_unit_ready;
    logic [31:0] w_unit_result;
    logic        w_timeout;

    // req_ready is only ever set while in IDLE, so it alone qualifies accept
    assign w_accept      = req_valid && r_req_ready;
    assign w_in_issue    = (r_state == ST_ISSUE);
    // Only the selected unit's handshake is looked at
    assign w_unit_ready  = (r_sel == SEL_F) ? f_ready  : m_ready;
    assign w_unit_result = (r_sel == SEL_F) ? f_result : m_result;

`ifdef VIGNA_COPROC_TIMEOUT_EN
    vigna_coproc_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_accept),
        .i_run     (w_in_issue),
        .o_expired (w_timeout)
    );
`else
    // Without the watchdog a request waits in ISSUE for as long as it takes,
    // which also keeps r_wb_err permanently 0.
    assign w_timeout = 1'b0;
`endif

    // Issue FSM: accept, hold operands during ISSUE, capture result, writeback
    always_ff @(posedge clk) begin
        // NOTE: synchronous reset clears every output register, including the
        // operand and tag registers, so nothing stale is visible after reset.
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b0;
            r_sel       <= SEL_M;
            r_func      <= 3'd0;
            r_func2     <= 5'd0;
            r_rd        <= 5'd0;
            r_op1       <= 32'd0;
            r_op2       <= 32'd0;
            r_id        <= 3'd0;
            r_m_valid   <= 1'b0;
            r_f_valid   <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_data   <= 32'd0;
            r_wb_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge register values regardless of statement order.
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel       <= req_sel;
                        r_func      <= req_func;
                        r_func2     <= req_func2;
                        r_rd        <= req_rd;
                        r_op1       <= req_op1;
                        r_op2       <= req_op2;
                        r_id        <= next_tag(r_id);
                        r_m_valid   <= (req_sel == SEL_M);
                        r_f_valid   <= (req_sel == SEL_F);
                        r_req_ready <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end

                ST_ISSUE: begin
                    // A real result wins over a timeout landing on the same edge
                    if (w_unit_ready || w_timeout) begin
                        r_m_valid <= 1'b0;
                        r_f_valid <= 1'b0;
                        if (r_rd != 5'd0) begin
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= w_unit_ready ? w_unit_result : 32'd0;
                            r_wb_err   <= !w_unit_ready;
                            r_state    <= ST_WB;
                        end else begin
                            r_req_ready <= 1'b1;
                            r_state     <= ST_IDLE;
                        end
                    end
                end

                ST_WB: begin
                    if (wb_ready) begin
                        r_wb_valid  <= 1'b0;
                        r_wb_err    <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_m_valid   <= 1'b0;
                    r_f_valid   <= 1'b0;
                    r_wb_valid  <= 1'b0;
                    r_req_ready <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign cp_func   = r_func;
    assign cp_func2  = r_func2;
    assign cp_id     = r_id;
    assign cp_op1    = r_op1;
    assign cp_op2    = r_op2;
    assign m_valid   = r_m_valid;
    assign f_valid   = r_f_valid;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_rd;
    assign wb_data   = r_wb_data;
    assign wb_err    = r_wb_err;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_vigna_coproc_issue.sv
// tb_vigna_coproc_issue: scoreboard bench for vigna_coproc_issue. The bench
// plays both coprocessor units and the writeback consumer; expected writeback
// records {err, rd, data} are queued when requests are driven and popped when
// wb_valid appears. Outputs are sampled on the falling edge.
module tb_vigna_coproc_issue;
    import vigna_coproc_pkg::*;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_sel = 1'b0;
    logic [2:0]  req_func = 3'd0;
    logic [4:0]  req_func2 = 5'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [31:0] req_op1 = 32'd0;
    logic [31:0] req_op2 = 32'd0;
    logic        req_ready;
    logic [2:0]  cp_func;
    logic [4:0]  cp_func2;
    logic [2:0]  cp_id;
    logic [31:0] cp_op1;
    logic [31:0] cp_op2;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_result = 32'd0;
    logic        f_valid;
    logic        f_ready = 1'b0;
    logic [31:0] f_result = 32'd0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_err;
    logic        busy;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [2:0]  exp_id = 3'd0;
    logic [37:0] sb_q[$];

    vigna_coproc_issue #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_func  (req_func),
        .req_func2 (req_func2),
        .req_rd    (req_rd),
        .req_op1   (req_op1),
        .req_op2   (req_op2),
        .cp_func   (cp_func),
        .cp_func2  (cp_func2),
        .cp_id     (cp_id),
        .cp_op1    (cp_op1),
        .cp_op2    (cp_op2),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_result  (m_result),
        .f_valid   (f_valid),
        .f_ready   (f_ready),
        .f_result  (f_result),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_err    (wb_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour of the M unit for the codes the bench exercises
    function automatic logic [31:0] m_ref(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        case (fn)
            M_MUL:   return a * b;
            M_DIVU:  return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            M_REMU:  return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Every output must read zero straight after a reset edge
    task automatic check_cleared(input string tag);
        n_checks++;
        if ({req_ready, busy, m_valid, f_valid, wb_valid, wb_err, wb_rd, wb_data,
             cp_func, cp_func2, cp_op1, cp_op2} !== 115'd0) begin
            n_fail++;
            $display("FAIL %s outputs_cleared got=%h exp=0", tag,
                     {req_ready, busy, m_valid, f_valid, wb_valid, wb_err, wb_rd, wb_data,
                      cp_func, cp_func2, cp_op1, cp_op2});
        end
        n_checks++;
        if (cp_id !== 3'd0) begin
            n_fail++;
            $display("FAIL %s cp_id got=%0d exp=0", tag, cp_id);
        end
    endtask

    // Present one request and return just after the edge that accepts it
    task automatic send_req(input logic sel, input logic [2:0] fn, input logic [4:0] fn2,
                            input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL req_ready_wait got=%b exp=1", req_ready);
        end
        req_valid = 1'b1;
        req_sel   = sel;
        req_func  = fn;
        req_func2 = fn2;
        req_rd    = rd;
        req_op1   = a;
        req_op2   = b;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_op1   = 32'hFFFF_0000;
        req_op2   = 32'h0000_FFFF;
        exp_id    = next_tag(exp_id);
    endtask

    // Act as the selected unit: hold ready low for 'latency' cycles while the
    // other unit's ready toggles as noise, then return 'result'
    task automatic serve(input logic sel, input int latency, input logic [31:0] result,
                         input logic [2:0] fn, input logic [4:0] fn2,
                         input logic [31:0] a, input logic [31:0] b, input string tag);
        for (int i = 0; i <= latency; i++) begin
            @(negedge clk);
            n_checks++;
            if ({m_valid, f_valid} !== ((sel == SEL_F) ? 2'b01 : 2'b10)) begin
                n_fail++;
                $display("FAIL %s valids got=%b exp=%b", tag, {m_valid, f_valid},
                         (sel == SEL_F) ? 2'b01 : 2'b10);
            end
            n_checks++;
            if ({cp_id, cp_func, cp_func2, cp_op1, cp_op2} !== {exp_id, fn, fn2, a, b}) begin
                n_fail++;
                $display("FAIL %s operands got=%h exp=%h", tag,
                         {cp_id, cp_func, cp_func2, cp_op1, cp_op2}, {exp_id, fn, fn2, a, b});
            end
            n_checks++;
            if ({busy, req_ready, wb_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL %s issue_status got=%b exp=100", tag, {busy, req_ready, wb_valid});
            end
            if (sel == SEL_F) begin
                m_ready  = 1'b1;
                m_result = 32'hBAD0_0000 | 32'(i);
            end else begin
                f_ready  = 1'b1;
                f_result = 32'hBAD1_0000 | 32'(i);
            end
            if (i == latency) begin
                if (sel == SEL_F) begin
                    f_ready  = 1'b1;
                    f_result = result;
                end else begin
                    m_ready  = 1'b1;
                    m_result = result;
                end
            end
        end
        @(posedge clk);
        #1;
        m_ready  = 1'b0;
        f_ready  = 1'b0;
        m_result = 32'hDEAD_BEEF;
        f_result = 32'hDEAD_BEEF;
        n_checks++;
        if ({m_valid, f_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s valid_drop got=%b exp=00", tag, {m_valid, f_valid});
        end
    endtask

    // Act as writeback: compare against the scoreboard, stall, then retire
    task automatic collect_wb(input int stall, input string tag);
        logic [37:0] exp;
        int          waited;
        waited = 0;
        exp = 38'd0;
        @(negedge clk);
        while (!wb_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard_empty got=0 exp>0", tag);
        end else begin
            exp = sb_q.pop_front();
        end
        n_checks++;
        if (wb_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s wb_valid got=%b exp=1", tag, wb_valid);
        end
        n_checks++;
        if ({wb_err, wb_rd, wb_data} !== exp) begin
            n_fail++;
            $display("FAIL %s wb_record got=%h exp=%h", tag, {wb_err, wb_rd, wb_data}, exp);
        end
        for (int i = 0; i < stall; i++) begin
            m_ready  = 1'b1;
            f_ready  = 1'b1;
            m_result = 32'h5555_0000 | 32'(i);
            f_result = 32'h6666_0000 | 32'(i);
            @(negedge clk);
            n_checks++;
            if ({wb_valid, req_ready, busy, wb_err, wb_rd, wb_data} !== {3'b101, exp}) begin
                n_fail++;
                $display("FAIL %s wb_stall%0d got=%h exp=%h", tag, i,
                         {wb_valid, req_ready, busy, wb_err, wb_rd, wb_data}, {3'b101, exp});
            end
        end
        m_ready  = 1'b0;
        f_ready  = 1'b0;
        wb_ready = 1'b1;
        @(posedge clk);
        #1;
        wb_ready = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({wb_valid, busy, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s wb_retire got=%b exp=001", tag, {wb_valid, busy, req_ready});
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_cleared("reset");
        resetn = 1'b1;
        exp_id = 3'd0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({req_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_idle got=%b exp=10", {req_ready, busy});
        end
    endtask

    task automatic test_mul();
        send_req(SEL_M, M_MUL, 5'd0, 5'd5, 32'd7, 32'd6);
        sb_q.push_back({1'b0, 5'd5, 32'd42});
        serve(SEL_M, 3, m_ref(M_MUL, 32'd7, 32'd6), M_MUL, 5'd0, 32'd7, 32'd6, "mul");
        collect_wb(0, "mul");
    endtask

    task automatic test_divu_zero();
        send_req(SEL_M, M_DIVU, 5'd0, 5'd3, 32'd100, 32'd0);
        sb_q.push_back({1'b0, 5'd3, 32'hFFFF_FFFF});
        serve(SEL_M, 1, m_ref(M_DIVU, 32'd100, 32'd0), M_DIVU, 5'd0, 32'd100, 32'd0, "divu0");
        collect_wb(0, "divu0");
    endtask

    task automatic test_fadd();
        send_req(SEL_F, 3'd0, F_FADD, 5'd1, 32'h3F80_0000, 32'h4000_0000);
        sb_q.push_back({1'b0, 5'd1, 32'h4040_0000});
        serve(SEL_F, 2, 32'h4040_0000, 3'd0, F_FADD, 32'h3F80_0000, 32'h4000_0000, "fadd");
        collect_wb(0, "fadd");
    endtask

    task automatic test_rd_zero();
        send_req(SEL_M, M_MUL, 5'd0, 5'd0, 32'd9, 32'd8);
        serve(SEL_M, 1, m_ref(M_MUL, 32'd9, 32'd8), M_MUL, 5'd0, 32'd9, 32'd8, "rd0");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({wb_valid, busy, req_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL rd0_discard%0d got=%b exp=001", i, {wb_valid, busy, req_ready});
            end
        end
    endtask

    task automatic test_backpressure();
        send_req(SEL_M, M_MUL, 5'd0, 5'd7, 32'd3, 32'd4);
        sb_q.push_back({1'b0, 5'd7, 32'd12});
        serve(SEL_M, 1, m_ref(M_MUL, 32'd3, 32'd4), M_MUL, 5'd0, 32'd3, 32'd4, "bp");
        collect_wb(10, "bp");
    endtask

    task automatic test_timeout();
        int cycles;
`ifdef VIGNA_COPROC_TIMEOUT_EN
        send_req(SEL_M, M_MUL, 5'd0, 5'd9, 32'd11, 32'd13);
        sb_q.push_back({1'b1, 5'd9, 32'd0});
        cycles = 0;
        do begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end while (!wb_valid && cycles < TMO + 16);
        n_checks++;
        if (cycles != TMO) begin
            n_fail++;
            $display("FAIL timeout_cycles got=%0d exp=%0d", cycles, TMO);
        end
        n_checks++;
        if ({m_valid, f_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_valid_drop got=%b exp=00", {m_valid, f_valid});
        end
        // Late ready pulses arrive during the stall and must not alter wb_data
        collect_wb(3, "timeout");
`else
        send_req(SEL_M, M_MUL, 5'd0, 5'd10, 32'd5, 32'd5);
        sb_q.push_back({1'b0, 5'd10, 32'd25});
        cycles = 0;
        for (int i = 0; i < TMO + 36; i++) begin
            @(negedge clk);
            cycles++;
            n_checks++;
            if ({m_valid, wb_valid, wb_err, busy} !== 4'b1001) begin
                n_fail++;
                $display("FAIL wait_forever%0d got=%b exp=1001", cycles, {m_valid, wb_valid, wb_err, busy});
            end
        end
        serve(SEL_M, 0, m_ref(M_MUL, 32'd5, 32'd5), M_MUL, 5'd0, 32'd5, 32'd5, "nowdog");
        collect_wb(0, "nowdog");
`endif
    endtask

    task automatic test_reset_mid_issue();
        send_req(SEL_M, M_MUL, 5'd0, 5'd6, 32'd9, 32'd9);
        @(negedge clk);
        n_checks++;
        if (m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pending got=%b exp=1", m_valid);
        end
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        exp_id = 3'd0;
        check_cleared("midrst");
        send_req(SEL_M, M_MUL, 5'd0, 5'd4, 32'd2, 32'd3);
        sb_q.push_back({1'b0, 5'd4, 32'd6});
        serve(SEL_M, 0, m_ref(M_MUL, 32'd2, 32'd3), M_MUL, 5'd0, 32'd2, 32'd3, "midrst_new");
        collect_wb(0, "midrst_new");
    endtask

    // Consecutive requests across both units; nine of them wrap the tag 7 -> 0
    task automatic test_back_to_back();
        logic        s;
        logic [2:0]  fn;
        logic [4:0]  fn2;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        for (int i = 0; i < 9; i++) begin
            s   = (i % 4 == 3) ? SEL_F : SEL_M;
            fn  = (i % 3 == 0) ? M_MUL : ((i % 3 == 1) ? M_DIVU : M_REMU);
            fn2 = (s == SEL_F) ? F_FMUL : 5'd0;
            rd  = 5'(i + 11);
            a   = $urandom;
            b   = (i == 2) ? 32'd0 : 32'($urandom_range(1, 1000));
            res = (s == SEL_F) ? $urandom : m_ref(fn, a, b);
            send_req(s, fn, fn2, rd, a, b);
            sb_q.push_back({1'b0, rd, res});
            serve(s, i % 3, res, fn, fn2, a, b, "b2b");
            collect_wb(i % 2, "b2b");
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_divu_zero();
        test_fadd();
        test_rd_zero();
        test_backpressure();
        test_timeout();
        test_reset_mid_issue();
        test_back_to_back();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
